// File: rtl/mem_lsu.sv
// Memory-access stage: issues handshaked data-bus transactions for loads and
// stores, stalls the pipeline while the bus is busy, formats load data and
// implements LL/SC. Non-memory instructions pass straight through.
module mem_lsu #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    mem_op_i,
  input  logic [DW-1:0] result_i,
  input  logic [DW-1:0] store_data_i,
  input  logic          en_wb_i,
  input  logic [4:0]    desReg_addr_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          en_hilo_i,
  input  logic          LLbit_i,
  input  logic          wb_LLbit_en_i,
  input  logic          wb_LLbit_data_i,
  output logic          bus_req_o,
  output logic          bus_we_o,
  output logic [DW-1:0] bus_addr_o,
  output logic [3:0]    bus_sel_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_ack_i,
  output logic [DW-1:0] result_o,
  output logic          en_wb_o,
  output logic [4:0]    desReg_addr_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          en_hilo_o,
  output logic          LLbit_en_o,
  output logic          LLbit_data_o,
  output logic          stallreq_o,
  output logic          misalign_o,
  output logic          bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  // Last counter value before giving up on the bus; an ack in that cycle still wins.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cnt;
  logic [DW-1:0] cap_data;
  logic          cap_err;

  logic          is_mem, is_store, misaligned, llbit_eff, sc_fail, access;

  // Big-endian lane extraction and sign/zero extension of read data.
  // SC completion yields 1; plain stores capture nothing useful.
  function automatic logic [DW-1:0] fmt_load(input logic [3:0] op,
                                             input logic [1:0] a,
                                             input logic [DW-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:        return {{24{b[7]}}, b};
      OP_LBU:       return {24'h0, b};
      OP_LH:        return {{16{h[15]}}, h};
      OP_LHU:       return {16'h0, h};
      OP_LW, OP_LL: return d;
      OP_SC:        return DW'(1);
      default:      return '0;
    endcase
  endfunction

  // Byte-lane enables; address 0 is the most significant lane.
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b1000 >> a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b0011 : 4'b1100;
      default:              return 4'b1111;
    endcase
  endfunction

  // Store data replicated into every lane so the memory picks it up via sel.
  function automatic logic [DW-1:0] lane_wdata(input logic [3:0] op, input logic [DW-1:0] rt);
    case (op)
      OP_SB:        return {4{rt[7:0]}};
      OP_SH:        return {2{rt[15:0]}};
      OP_SW, OP_SC: return rt;
      default:      return '0;
    endcase
  endfunction

  // Classify the incoming instruction: misaligned, failed SC, or real bus access.
  always_comb begin
    is_mem     = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SC);
    is_store   = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) ||
                 (mem_op_i == OP_SW) || (mem_op_i == OP_SC);
    misaligned = (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) &&
                  result_i[0]) ||
                 (((mem_op_i == OP_LW) || (mem_op_i == OP_SW) ||
                   (mem_op_i == OP_LL) || (mem_op_i == OP_SC)) && (result_i[1:0] != 2'b00));
    llbit_eff  = wb_LLbit_en_i ? wb_LLbit_data_i : LLbit_i;
    sc_fail    = (mem_op_i == OP_SC) && !llbit_eff && !misaligned;
    access     = is_mem && !misaligned && !sc_fail;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and all outputs toward mem_wb and ctrl.
  always_comb begin
    state_nxt     = state;
    result_o      = result_i;
    en_wb_o       = en_wb_i;
    desReg_addr_o = desReg_addr_i;
    hi_o          = hi_i;
    lo_o          = lo_i;
    en_hilo_o     = en_hilo_i;
    LLbit_en_o    = 1'b0;
    LLbit_data_o  = 1'b0;
    stallreq_o    = 1'b0;
    misalign_o    = 1'b0;
    bus_err_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (misaligned) begin
          misalign_o = 1'b1;
          en_wb_o    = 1'b0;
          en_hilo_o  = 1'b0;
        end else if (sc_fail) begin
          result_o = '0;
        end else if (access) begin
          stallreq_o = 1'b1;
          result_o   = '0;
          en_wb_o    = 1'b0;
          en_hilo_o  = 1'b0;
          state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        result_o   = '0;
        en_wb_o    = 1'b0;
        en_hilo_o  = 1'b0;
        if (bus_ack_i || (cnt == CNT_LAST)) state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
        if (cap_err) begin
          bus_err_o = 1'b1;
          en_wb_o   = 1'b0;
          result_o  = '0;
        end else begin
          result_o = cap_data;
          if (mem_op_i == OP_LL) begin
            LLbit_en_o   = 1'b1;
            LLbit_data_o = 1'b1;
          end else if (mem_op_i == OP_SC) begin
            LLbit_en_o   = 1'b1;
            LLbit_data_o = 1'b0;
          end
        end
      end
    endcase
  end

  // Bus request fields, timeout counter and captured completion data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      cnt         <= '0;
      cap_data    <= '0;
      cap_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {result_i[DW-1:2], 2'b00};
            bus_sel_o   <= lane_sel(mem_op_i, result_i[1:0]);
            bus_wdata_o <= lane_wdata(mem_op_i, store_data_i);
            cnt         <= '0;
            cap_err     <= 1'b0;
          end
        end
        S_BUSY: begin
          cnt <= cnt + 8'd1;
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            cap_data  <= fmt_load(mem_op_i, result_i[1:0], bus_rdata_i);
            cap_err   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            bus_req_o <= 1'b0;
            cap_data  <= '0;
            cap_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed scenarios followed by randomized
// instructions checked against a behavioural model of the load/store rules.
module tb_mem_lsu;

  localparam int OP_LB = 1, OP_LBU = 2, OP_LH = 3, OP_LHU = 4, OP_LW = 5;
  localparam int OP_SB = 6, OP_SH = 7, OP_SW = 8, OP_LL = 9, OP_SC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_op;
  logic [31:0] result_in, store_data, hi_in, lo_in, bus_rdata;
  logic        en_wb_in, en_hilo_in, llbit, wb_ll_en, wb_ll_data, bus_ack;
  logic [4:0]  dreg_in;

  logic        bus_req, bus_we, en_wb_out, en_hilo_out, ll_en_out, ll_data_out;
  logic        stallreq, misalign, bus_err;
  logic [31:0] bus_addr, bus_wdata, result_out, hi_out, lo_out;
  logic [3:0]  bus_sel;
  logic [4:0]  dreg_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_lsu #(.DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_op_i(mem_op), .result_i(result_in),
    .store_data_i(store_data), .en_wb_i(en_wb_in), .desReg_addr_i(dreg_in),
    .hi_i(hi_in), .lo_i(lo_in), .en_hilo_i(en_hilo_in), .LLbit_i(llbit),
    .wb_LLbit_en_i(wb_ll_en), .wb_LLbit_data_i(wb_ll_data),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .result_o(result_out), .en_wb_o(en_wb_out),
    .desReg_addr_o(dreg_out), .hi_o(hi_out), .lo_o(lo_out),
    .en_hilo_o(en_hilo_out), .LLbit_en_o(ll_en_out), .LLbit_data_o(ll_data_out),
    .stallreq_o(stallreq), .misalign_o(misalign), .bus_err_o(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input int op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    if (op == OP_LW || op == OP_SW || op == OP_LL || op == OP_SC) return 4;
    return 0;
  endfunction

  function automatic bit is_store_op(input int op);
    return (op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SC);
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int     sz  = op_size(op);
    int     off = int'(addr % 4);
    longint v;
    v = (longint'(rd) >> (8 * (4 - sz - off))) & ((64'd1 << (8 * sz)) - 1);
    if ((op == OP_LB || op == OP_LH) && v >= (64'd1 << (8 * sz - 1)))
      v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_sel(input int op, input logic [31:0] addr);
    int sz  = op_size(op);
    int off = int'(addr % 4);
    int m   = ((1 << sz) - 1) << (4 - sz - off);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int op, input logic [31:0] rt);
    int sz = op_size(op);
    if (sz == 1) return (rt % 256) * 32'h01010101;
    if (sz == 2) return (rt % 65536) * 32'h00010001;
    return rt;
  endfunction

  // ---------------- step helpers ----------------
  task automatic check_pass(input string tag);
    #1;
    check({tag, ".stall"}, 32'(stallreq), 32'd0);
    check({tag, ".result"}, result_out, result_in);
    check({tag, ".en_wb"}, 32'(en_wb_out), 32'(en_wb_in));
    check({tag, ".en_hilo"}, 32'(en_hilo_out), 32'(en_hilo_in));
    check({tag, ".hi"}, hi_out, hi_in);
    check({tag, ".dreg"}, 32'(dreg_out), 32'(dreg_in));
    check({tag, ".llen"}, 32'(ll_en_out), 32'd0);
    @(posedge clk); #1;
    check({tag, ".noreq"}, 32'(bus_req), 32'd0);
  endtask

  task automatic check_mis(input string tag);
    #1;
    check({tag, ".misalign"}, 32'(misalign), 32'd1);
    check({tag, ".en_wb"}, 32'(en_wb_out), 32'd0);
    check({tag, ".en_hilo"}, 32'(en_hilo_out), 32'd0);
    check({tag, ".stall"}, 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    check({tag, ".noreq"}, 32'(bus_req), 32'd0);
  endtask

  task automatic check_scfail(input string tag);
    #1;
    check({tag, ".result"}, result_out, 32'd0);
    check({tag, ".en_wb"}, 32'(en_wb_out), 32'(en_wb_in));
    check({tag, ".stall"}, 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    check({tag, ".noreq"}, 32'(bus_req), 32'd0);
  endtask

  // Inputs already driven for the IDLE cycle; ack is given in request cycle k.
  task automatic run_access(input string tag, input int k, input logic [31:0] rd,
                            input bit chk_res, input logic [31:0] exp_res,
                            input logic exp_llen, input logic exp_lld);
    int op = int'(mem_op);
    int stalls = 0;
    logic [31:0] r;
    #1;
    check({tag, ".idle_stall"}, 32'(stallreq), 32'd1);
    check({tag, ".idle_bubble"}, result_out, 32'd0);
    if (stallreq) stalls++;
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      r = $urandom;
      bus_ack   = (i == k);
      bus_rdata = (i == k) ? rd : r;
      #1;
      if (stallreq) stalls++;
      check({tag, ".req"}, 32'(bus_req), 32'd1);
      check({tag, ".addr"}, bus_addr, {result_in[31:2], 2'b00});
      check({tag, ".sel"}, 32'(bus_sel), 32'(model_sel(op, result_in)));
      check({tag, ".we"}, 32'(bus_we), 32'(is_store_op(op)));
      if (is_store_op(op)) check({tag, ".wdata"}, bus_wdata, model_wdata(op, store_data));
    end
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(k + 1));
    check({tag, ".done_stall"}, 32'(stallreq), 32'd0);
    check({tag, ".done_req"}, 32'(bus_req), 32'd0);
    check({tag, ".done_err"}, 32'(bus_err), 32'd0);
    check({tag, ".done_en_wb"}, 32'(en_wb_out), 32'(en_wb_in));
    check({tag, ".done_llen"}, 32'(ll_en_out), 32'(exp_llen));
    if (exp_llen) check({tag, ".done_lld"}, 32'(ll_data_out), 32'(exp_lld));
    if (chk_res) check({tag, ".done_result"}, result_out, exp_res);
  endtask

  task automatic drive(input int op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic enwb);
    mem_op     = 4'(op);
    result_in  = addr;
    store_data = rt;
    en_wb_in   = enwb;
  endtask

  initial begin
    logic [31:0] r, a, rd;
    int op, k, sz;
    logic eff;

    rst_n = 1'b0; mem_op = '0; result_in = '0; store_data = '0; hi_in = '0; lo_in = '0;
    en_wb_in = 1'b0; en_hilo_in = 1'b0; llbit = 1'b0; wb_ll_en = 1'b0; wb_ll_data = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0; dreg_in = '0;

    // Reset state
    #12;
    check("rst.req", 32'(bus_req), 32'd0);
    check("rst.we", 32'(bus_we), 32'd0);
    check("rst.addr", bus_addr, 32'd0);
    check("rst.sel", 32'(bus_sel), 32'd0);
    check("rst.wdata", bus_wdata, 32'd0);
    check("rst.result", result_out, 32'd0);
    check("rst.en_wb", 32'(en_wb_out), 32'd0);
    check("rst.stall", 32'(stallreq), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Non-memory op passes straight through
    @(negedge clk); drive(0, 32'h12345678, 32'h0, 1'b1); dreg_in = 5'd7;
    check_pass("nonmem");

    // LB / LBU at 0x1001, ack in the second request cycle
    @(negedge clk); drive(OP_LB, 32'h00001001, 32'h0, 1'b1);
    run_access("lb", 2, 32'h11F02233, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0);
    check("lb.sel_const", 32'(bus_sel), 32'h4);
    @(negedge clk); drive(OP_LBU, 32'h00001001, 32'h0, 1'b1);
    run_access("lbu", 2, 32'h11F02233, 1'b1, 32'h000000F0, 1'b0, 1'b0);

    // SH at 0x2002
    @(negedge clk); drive(OP_SH, 32'h00002002, 32'hAAAABEEF, 1'b0);
    run_access("sh", 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("sh.sel_const", 32'(bus_sel), 32'h3);
    check("sh.wdata_const", bus_wdata, 32'hBEEFBEEF);

    // LL then SC with forwarded LLbit
    @(negedge clk); drive(OP_LL, 32'h00003000, 32'h0, 1'b1);
    run_access("ll", 1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
    @(negedge clk); drive(OP_SC, 32'h00003000, 32'h55667788, 1'b1);
    llbit = 1'b0; wb_ll_en = 1'b1; wb_ll_data = 1'b1;
    run_access("sc", 3, 32'h0, 1'b1, 32'h00000001, 1'b1, 1'b0);
    @(negedge clk); drive(OP_SC, 32'h00003000, 32'h55667788, 1'b1);
    llbit = 1'b1; wb_ll_en = 1'b1; wb_ll_data = 1'b0;
    check_scfail("sc_fail_fwd");
    @(negedge clk); drive(OP_SC, 32'h00003000, 32'h55667788, 1'b1);
    llbit = 1'b0; wb_ll_en = 1'b0;
    check_scfail("sc_fail");

    // Misaligned LW
    @(negedge clk); drive(OP_LW, 32'h00004002, 32'h0, 1'b1); en_hilo_in = 1'b1;
    check_mis("lw_mis");
    en_hilo_in = 1'b0;

    // Ack exactly on the last allowed cycle: ack wins
    @(negedge clk); drive(OP_LW, 32'h00006000, 32'h0, 1'b1);
    run_access("lw_lastack", 4, 32'h89ABCDEF, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0);

    // SW never acknowledged: timeout after four request cycles
    @(negedge clk); drive(OP_SW, 32'h00005000, 32'h01020304, 1'b1);
    #1; check("to.idle_stall", 32'(stallreq), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      check("to.req", 32'(bus_req), 32'd1);
      check("to.stall", 32'(stallreq), 32'd1);
    end
    @(negedge clk); #1;
    check("to.err", 32'(bus_err), 32'd1);
    check("to.stall_rel", 32'(stallreq), 32'd0);
    check("to.req_drop", 32'(bus_req), 32'd0);
    check("to.en_wb", 32'(en_wb_out), 32'd0);
    check("to.result", result_out, 32'd0);
    @(negedge clk); drive(0, 32'h0, 32'h0, 1'b0); #1;
    check("to.err_pulse", 32'(bus_err), 32'd0);

    // Reset in the middle of BUSY drops the request at once; late ack ignored
    @(negedge clk); drive(OP_SW, 32'h00007000, 32'hDEADBEEF, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    check("rstmid.req_before", 32'(bus_req), 32'd1);
    @(negedge clk); rst_n = 1'b0; drive(0, 32'h0, 32'h0, 1'b0); #1;
    check("rstmid.req", 32'(bus_req), 32'd0);
    check("rstmid.stall", 32'(stallreq), 32'd0);
    @(negedge clk); rst_n = 1'b1; bus_ack = 1'b1;
    @(posedge clk); #1;
    check("lateack.req", 32'(bus_req), 32'd0);
    check("lateack.err", 32'(bus_err), 32'd0);
    check("lateack.stall", 32'(stallreq), 32'd0);
    @(negedge clk); bus_ack = 1'b0;

    // Randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      op = int'($urandom_range(0, 15));
      a = $urandom;
      r = $urandom;
      drive(op, a, r, 1'(($urandom >> 3) & 1));
      r = $urandom;
      hi_in = r;
      r = $urandom;
      lo_in = r;
      dreg_in    = 5'($urandom_range(0, 31));
      en_hilo_in = 1'($urandom_range(0, 1));
      llbit      = 1'($urandom_range(0, 1));
      wb_ll_en   = 1'($urandom_range(0, 1));
      wb_ll_data = 1'($urandom_range(0, 1));
      eff = wb_ll_en ? wb_ll_data : llbit;
      sz = op_size(op);
      if (sz == 0) begin
        check_pass("rnd.pass");
      end else if ((a % sz) != 0) begin
        check_mis("rnd.mis");
      end else if (op == OP_SC && !eff) begin
        check_scfail("rnd.scfail");
      end else begin
        k = int'($urandom_range(1, 4));
        rd = $urandom;
        if (op == OP_SC)
          run_access("rnd.sc", k, rd, 1'b1, 32'd1, 1'b1, 1'b0);
        else if (is_store_op(op))
          run_access("rnd.st", k, rd, 1'b0, 32'd0, 1'b0, 1'b0);
        else
          run_access("rnd.ld", k, rd, 1'b1, model_load(op, a, rd),
                     1'(op == OP_LL), 1'b1);
      end
    end

    @(negedge clk); drive(0, 32'h0, 32'h0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
